pwm_decoder: RTL



---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_decoder_sync_edge.sv | 31 +++
 rtl/pwm_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM audio receive path.
package pwm_pkg;

    localparam int PWM_WIDTH  = 11;
    localparam int PWM_FRAME  = 2**PWM_WIDTH;
    localparam int LOCK_COUNT = 2;

    typedef enum logic {
        HUNT    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_decoder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous 1-bit input, followed by an
// extra delay flop that provides registered rise/fall strobes.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              level_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            level_d_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[STAGES-2:0], din};
            level_d_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~level_d_reg;
    assign fall  = ~level & level_d_reg;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers one WIDTH-bit duty value per PWM frame from a looped-back PWM stream.
// Define PWM_DEC_AVG_EN to output a 4-tap boxcar average instead of raw values.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**WIDTH + 16
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             frame_err,
    input  logic             err_clr,
    output logic             locked
);

    localparam int            CW          = WIDTH + 2;
    localparam logic [CW-1:0] FRAME_LEN   = CW'(2**WIDTH);
    localparam logic [CW-1:0] TIMEOUT_LEN = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [CW-1:0] CLAMP_CW    = CW'((2**WIDTH) - 1);
    localparam logic [1:0]    LOCK_GOOD   = 2'(LOCK_COUNT);

    logic level, rise, unused_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (unused_fall)
    );

    state_t            state_reg, state_next;
    logic [CW-1:0]     period_cnt_reg, period_cnt_next;
    logic [CW-1:0]     high_cnt_reg, high_cnt_next;
    logic [1:0]        good_cnt_reg, good_cnt_next;
    logic              locked_reg, locked_next;
    logic              frame_err_reg, frame_err_next;
    logic [WIDTH-1:0]  sample_reg, sample_next;
    logic              sample_valid_reg;

    logic              frame_done, timeout, bad_period, raw_event;
    logic [WIDTH-1:0]  raw_value;

    assign frame_done = (state_reg == MEASURE) && rise;
    assign timeout    = !rise && (period_cnt_reg >= TIMEOUT_LEN);
    assign bad_period = frame_done && (period_cnt_reg != FRAME_LEN);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg        <= HUNT;
            period_cnt_reg   <= '0;
            high_cnt_reg     <= '0;
            good_cnt_reg     <= '0;
            locked_reg       <= 1'b0;
            frame_err_reg    <= 1'b0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            period_cnt_reg   <= period_cnt_next;
            high_cnt_reg     <= high_cnt_next;
            good_cnt_reg     <= good_cnt_next;
            locked_reg       <= locked_next;
            frame_err_reg    <= frame_err_next;
            sample_valid_reg <= raw_event;
            if (raw_event) begin
                sample_reg <= sample_next;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (rise) begin
            state_next = MEASURE;
        end else if (timeout) begin
            state_next = HUNT;
        end
    end

    // A timeout reloads the period counter to 0 so a held level re-emits every TIMEOUT+1 clocks.
    always_comb begin
        period_cnt_next = period_cnt_reg;
        high_cnt_next   = high_cnt_reg;
        if (rise) begin
            period_cnt_next = CW'(1);
            high_cnt_next   = CW'(1);
        end else if (timeout) begin
            period_cnt_next = '0;
            high_cnt_next   = '0;
        end else begin
            if (period_cnt_reg != CNT_MAX) begin
                period_cnt_next = period_cnt_reg + CW'(1);
            end
            if ((state_reg == MEASURE) && level && (high_cnt_reg != CNT_MAX)) begin
                high_cnt_next = high_cnt_reg + CW'(1);
            end
        end
    end

    // A new period error overrides a same-cycle clear.
    always_comb begin
        good_cnt_next  = good_cnt_reg;
        locked_next    = locked_reg;
        frame_err_next = frame_err_reg;
        if (err_clr) begin
            frame_err_next = 1'b0;
        end
        if (bad_period) begin
            frame_err_next = 1'b1;
            good_cnt_next  = '0;
            locked_next    = 1'b0;
        end else if (frame_done) begin
            if (good_cnt_reg != LOCK_GOOD) begin
                good_cnt_next = good_cnt_reg + 2'd1;
            end
            locked_next = (good_cnt_next == LOCK_GOOD);
        end
    end

    always_comb begin
        raw_event = frame_done || timeout;
        raw_value = '0;
        if (frame_done) begin
            raw_value = (high_cnt_reg > CLAMP_CW) ? CLAMP_CW[WIDTH-1:0] : high_cnt_reg[WIDTH-1:0];
        end else if (timeout) begin
            raw_value = level ? CLAMP_CW[WIDTH-1:0] : '0;
        end
    end

`ifdef PWM_DEC_AVG_EN
    logic [2:0][WIDTH-1:0] hist_reg;
    logic [CW-1:0]         avg_sum;

    always_comb begin
        avg_sum = CW'(raw_value);
        for (int i = 0; i < 3; i++) begin
            avg_sum = avg_sum + CW'(hist_reg[i]);
        end
        sample_next = avg_sum[CW-1:2];
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            hist_reg <= '0;
        end else if (raw_event) begin
            hist_reg <= {hist_reg[1:0], raw_value};
        end
    end
`else
    assign sample_next = raw_value;
`endif

    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;
    assign frame_err    = frame_err_reg;
    assign locked       = locked_reg;

endmodule
